// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer
// Description : Multi-channel interrupt sequencer placed between fetch, IF/ID
//               and decode. Rising edges on the request lines are latched as
//               pending. Pending requests are masked and prioritised (index 0
//               is the highest priority). An accepted request freezes fetch,
//               injects a two-word PC-save sequence into decode and then
//               redirects fetch to the vector of the channel. A nesting stack
//               of {id, resume PC} lets a higher-priority request preempt a
//               running ISR. RTI pops the stack and redirects fetch back to
//               the saved PC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1         clock, rising edge
//   reset          in   1         asynchronous, active-low reset
//   irq            in   NUM_IRQ   request lines; a rising edge sets pending
//   mask_we        in   1         mask register write enable
//   mask_wdata     in   NUM_IRQ   new mask; 1 = channel disabled
//   next_pc        in   PC_W      resume PC of the instruction in fetch
//   stall          in   1         pipeline stall; sequence and outputs hold
//   rti            in   1         one-cycle pulse: RTI decoded
//   fetch_hold     out  1         freeze PC / IF-ID fill
//   inj_valid      out  1         inj_inst replaces the IF/ID instruction
//   inj_inst       out  INST_W    injected instruction
//   redirect_valid out  1         load redirect_pc into PC
//   redirect_pc    out  PC_W      channel vector or restored PC
//   saved_pc       out  PC_W      PC being saved (valid in INJ_HI / INJ_LO)
//   irq_ack        out  NUM_IRQ   one-hot acknowledge of the accepted channel
//   in_isr         out  1         nesting stack not empty
//   active_id      out  ID_W      channel on top of the stack; 0 when empty
//   err            out  1         sticky: RTI seen with an empty stack
// ============================================================================
module irq_sequencer #(
  parameter int                NUM_IRQ      = 4,
  parameter int                PC_W         = 32,
  parameter int                INST_W       = 16,
  parameter int                NEST_DEPTH   = 2,
  parameter logic [PC_W-1:0]   VEC_BASE     = 32'h0000_0010,
  parameter logic [PC_W-1:0]   VEC_STRIDE   = 32'h0000_0008,
  parameter logic [INST_W-1:0] PUSH_HI_INST = 16'hF801,
  parameter logic [INST_W-1:0] PUSH_LO_INST = 16'hF802,
  localparam int               ID_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               stall,
  input  logic               rti,
  output logic               fetch_hold,
  output logic               inj_valid,
  output logic [INST_W-1:0]  inj_inst,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    saved_pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic [ID_W-1:0]    active_id,
  output logic               err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  localparam logic [DEPTH_W-1:0] c_depth_full = DEPTH_W'(NEST_DEPTH);
  localparam logic [DEPTH_W-1:0] c_depth_one  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] c_depth_zero = '0;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_hold   = 3'd1;
  localparam logic [2:0] c_st_inj_hi = 3'd2;
  localparam logic [2:0] c_st_inj_lo = 3'd3;
  localparam logic [2:0] c_st_vector = 3'd4;
  localparam logic [2:0] c_st_return = 3'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [DEPTH_W-1:0] r_depth;
  logic [ID_W-1:0]    r_stk_id [NEST_DEPTH];
  logic [PC_W-1:0]    r_stk_pc [NEST_DEPTH];
  logic               r_err;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic               w_any_elig;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_top_id;
  logic [PC_W-1:0]    w_top_pc;
  logic [PC_W-1:0]    w_pop_pc;
  logic [PC_W-1:0]    w_vec;
  logic               w_prio_ok;
  logic               w_accept;
  logic [NUM_IRQ-1:0] w_ack_clr;

  assign w_rise = irq & ~r_irq_q;
  // The mask register is used as currently stored, so a write in the accept
  // cycle only influences arbitration from the following cycle.
  assign w_elig     = r_pending & ~r_mask;
  assign w_any_elig = |w_elig;

  // Fixed priority: lowest set index wins.
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win = ID_W'(i);
      end
    end
  end

  // Stack views. Entries stay in place after a pop, so slot [r_depth] still
  // holds the entry just removed; RETURN uses it as the restore address.
  always_comb begin
    w_top_id = '0;
    w_top_pc = '0;
    w_pop_pc = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (r_depth == DEPTH_W'(i + 1)) begin
        w_top_id = r_stk_id[i];
        w_top_pc = r_stk_pc[i];
      end
      if (r_depth == DEPTH_W'(i)) begin
        w_pop_pc = r_stk_pc[i];
      end
    end
  end

  // Vector address of the channel on top of the stack, modulo 2^PC_W.
  assign w_vec = VEC_BASE + (PC_W'(w_top_id) * VEC_STRIDE);

  // With an empty stack any channel may enter; otherwise only a strictly
  // higher-priority channel (smaller index) may preempt the running ISR.
  assign w_prio_ok = (r_depth == c_depth_zero) || (w_win < w_top_id);

  // RTI has precedence over a new acceptance in the same IDLE cycle.
  assign w_accept = (r_state == c_st_idle) && !stall && !rti &&
                    (r_depth < c_depth_full) && w_any_elig && w_prio_ok;

  assign w_ack_clr = w_accept ? (NUM_IRQ'(1) << w_win) : '0;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_st_idle;
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_depth   <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        r_stk_id[i] <= '0;
        r_stk_pc[i] <= '0;
      end
    end else begin
      // Edge detection and mask updates keep running through a stall so no
      // request edge is missed while the pipeline is frozen.
      r_irq_q   <= irq;
      // A new edge on a channel in its own accept cycle survives the clear.
      r_pending <= (r_pending & ~w_ack_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end

      if (!stall) begin
        case (r_state)
          c_st_idle: begin
            if (rti) begin
              if (r_depth != c_depth_zero) begin
                r_depth <= r_depth - c_depth_one;
                r_state <= c_st_return;
              end else begin
                r_err <= 1'b1;
              end
            end else if (w_accept) begin
              for (int i = 0; i < NEST_DEPTH; i++) begin
                if (r_depth == DEPTH_W'(i)) begin
                  r_stk_id[i] <= w_win;
                  r_stk_pc[i] <= next_pc;
                end
              end
              r_depth <= r_depth + c_depth_one;
              r_state <= c_st_hold;
            end
          end
          c_st_hold:   r_state <= c_st_inj_hi;
          c_st_inj_hi: r_state <= c_st_inj_lo;
          c_st_inj_lo: r_state <= c_st_vector;
          c_st_vector: r_state <= c_st_idle;
          c_st_return: r_state <= c_st_idle;
          default:     r_state <= c_st_idle;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded purely from registered state, so they hold unchanged
  // whenever a stall freezes the sequence, and fall to 0 as soon as the
  // asynchronous reset clears the registers.
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_hold     = 1'b0;
    inj_valid      = 1'b0;
    inj_inst       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    saved_pc       = '0;
    irq_ack        = '0;
    case (r_state)
      c_st_hold: begin
        fetch_hold = 1'b1;
        irq_ack    = NUM_IRQ'(1) << w_top_id;
      end
      c_st_inj_hi: begin
        fetch_hold = 1'b1;
        inj_valid  = 1'b1;
        inj_inst   = PUSH_HI_INST;
        saved_pc   = w_top_pc;
      end
      c_st_inj_lo: begin
        fetch_hold = 1'b1;
        inj_valid  = 1'b1;
        inj_inst   = PUSH_LO_INST;
        saved_pc   = w_top_pc;
      end
      c_st_vector: begin
        fetch_hold     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = w_vec;
      end
      c_st_return: begin
        redirect_valid = 1'b1;
        redirect_pc    = w_pop_pc;
      end
      default: begin
        fetch_hold = 1'b0;
      end
    endcase
  end

  assign in_isr    = (r_depth != c_depth_zero);
  assign active_id = w_top_id;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sequencer
// Description : Scoreboard bench for irq_sequencer. Each scenario pushes the
//               acknowledges, injected words and redirects it expects; a
//               monitor pops and compares them as the sequencer emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] next_pc;
  logic        stall;
  logic        rti;
  logic        fetch_hold;
  logic        inj_valid;
  logic [15:0] inj_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] saved_pc;
  logic [3:0]  irq_ack;
  logic        in_isr;
  logic [1:0]  active_id;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_redir [$];
  logic [3:0]  exp_ack   [$];
  logic [15:0] exp_inst  [$];
  logic [31:0] exp_spc   [$];

  logic [31:0] m_pc;
  logic [3:0]  m_ack;
  logic [15:0] m_inst;
  logic [90:0] obs;

  assign obs = {fetch_hold, inj_valid, inj_inst, redirect_valid, redirect_pc,
                saved_pc, irq_ack, in_isr, active_id, err};

  always #5 clk = ~clk;

  irq_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .mask_we        (mask_we),
    .mask_wdata     (mask_wdata),
    .next_pc        (next_pc),
    .stall          (stall),
    .rti            (rti),
    .fetch_hold     (fetch_hold),
    .inj_valid      (inj_valid),
    .inj_inst       (inj_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .saved_pc       (saved_pc),
    .irq_ack        (irq_ack),
    .in_isr         (in_isr),
    .active_id      (active_id),
    .err            (err)
  );

  // Monitor: an event is consumed at the edge following a non-stalled cycle.
  always @(negedge clk) begin
    if (reset === 1'b1 && stall === 1'b0) begin
      if (redirect_valid) begin
        checks++;
        if (exp_redir.size() == 0) begin
          errors++;
          $display("FAIL redirect_unexpected: got pc %h, required no redirect", redirect_pc);
        end else begin
          m_pc = exp_redir.pop_front();
          if (redirect_pc !== m_pc) begin
            errors++;
            $display("FAIL redirect_pc: got %h, required %h", redirect_pc, m_pc);
          end
        end
      end
      if (irq_ack != 4'b0000) begin
        checks++;
        if (exp_ack.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got %b, required none", irq_ack);
        end else begin
          m_ack = exp_ack.pop_front();
          if (irq_ack !== m_ack) begin
            errors++;
            $display("FAIL irq_ack: got %b, required %b", irq_ack, m_ack);
          end
        end
      end
      if (inj_valid) begin
        checks++;
        if (exp_inst.size() == 0) begin
          errors++;
          $display("FAIL inj_unexpected: got %h, required none", inj_inst);
        end else begin
          m_inst = exp_inst.pop_front();
          m_pc   = exp_spc.pop_front();
          if (inj_inst !== m_inst || saved_pc !== m_pc) begin
            errors++;
            $display("FAIL inj_word: got inst %h saved %h, required inst %h saved %h",
                     inj_inst, saved_pc, m_inst, m_pc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rti();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_redir.size() == 0 && exp_ack.size() == 0 && exp_inst.size() == 0) break;
      tick();
    end
  endtask

  task automatic expect_entry(input logic [3:0] ack, input logic [31:0] pc, input logic [31:0] vec);
    exp_ack.push_back(ack);
    exp_inst.push_back(16'hF801); exp_spc.push_back(pc);
    exp_inst.push_back(16'hF802); exp_spc.push_back(pc);
    exp_redir.push_back(vec);
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0;
    next_pc = '0; stall = 1'b0; rti = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (in_isr !== 1'b0 || err !== 1'b0 || fetch_hold !== 1'b0) begin
      errors++; $display("FAIL reset_release: got in_isr %b err %b hold %b, required 0 0 0", in_isr, err, fetch_hold);
    end
  endtask

  task automatic test_basic();
    int lat;
    next_pc = 32'h40;
    expect_entry(4'b0100, 32'h40, 32'h20);
    irq = 4'b0100;
    tick();
    checks++;
    if (irq_ack !== 4'b0000) begin
      errors++; $display("FAIL basic_ack_early: got %b, required 0000", irq_ack);
    end
    tick();
    checks++;
    if (irq_ack !== 4'b0100 || fetch_hold !== 1'b1) begin
      errors++; $display("FAIL basic_ack: got ack %b hold %b, required 0100 1", irq_ack, fetch_hold);
    end
    lat = 2;
    for (int i = 0; i < 20; i++) begin
      if (redirect_valid) break;
      tick(); lat++;
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency: got %0d, required 5", lat);
    end
    checks++;
    if (active_id !== 2'd2 || in_isr !== 1'b1) begin
      errors++; $display("FAIL basic_active: got id %0d isr %b, required 2 1", active_id, in_isr);
    end
    tick();
    checks++;
    if (fetch_hold !== 1'b0) begin
      errors++; $display("FAIL basic_release: got hold %b, required 0", fetch_hold);
    end
    drain(10);
    irq = '0;
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0) begin
      errors++; $display("FAIL basic_drain: got %0d outstanding, required 0", exp_redir.size() + exp_ack.size() + exp_inst.size());
    end
  endtask

  task automatic test_nest();
    next_pc = 32'h80;
    expect_entry(4'b0001, 32'h80, 32'h10);
    irq = 4'b0001;
    drain(20);
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0 || active_id !== 2'd0 || in_isr !== 1'b1) begin
      errors++; $display("FAIL nest_preempt: got outstanding %0d id %0d, required 0 0", exp_redir.size() + exp_ack.size() + exp_inst.size(), active_id);
    end
    exp_redir.push_back(32'h80);
    pulse_rti();
    drain(10);
    checks++;
    if (exp_redir.size() != 0 || active_id !== 2'd2 || in_isr !== 1'b1) begin
      errors++; $display("FAIL nest_rti1: got outstanding %0d id %0d, required 0 2", exp_redir.size(), active_id);
    end
    exp_redir.push_back(32'h40);
    pulse_rti();
    drain(10);
    checks++;
    if (exp_redir.size() != 0 || in_isr !== 1'b0) begin
      errors++; $display("FAIL nest_rti2: got outstanding %0d isr %b, required 0 0", exp_redir.size(), in_isr);
    end
    irq = '0;
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    next_pc = 32'h100;
    expect_entry(4'b1000, 32'h100, 32'h28);
    irq = 4'b1001;
    drain(20);
    tick(); tick(); tick();
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0 || active_id !== 2'd3) begin
      errors++; $display("FAIL mask_ch3: got outstanding %0d id %0d, required 0 3", exp_redir.size() + exp_ack.size() + exp_inst.size(), active_id);
    end
    next_pc = 32'h200;
    expect_entry(4'b0001, 32'h200, 32'h10);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    drain(20);
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0 || active_id !== 2'd0) begin
      errors++; $display("FAIL mask_unmask: got outstanding %0d id %0d, required 0 0", exp_redir.size() + exp_ack.size() + exp_inst.size(), active_id);
    end
    exp_redir.push_back(32'h200);
    pulse_rti();
    drain(10);
    exp_redir.push_back(32'h100);
    pulse_rti();
    drain(10);
    checks++;
    if (exp_redir.size() != 0 || in_isr !== 1'b0) begin
      errors++; $display("FAIL mask_unwind: got outstanding %0d isr %b, required 0 0", exp_redir.size(), in_isr);
    end
    irq = '0;
  endtask

  task automatic test_rti_irq();
    next_pc = 32'h300;
    expect_entry(4'b0010, 32'h300, 32'h18);
    irq = 4'b0010;
    drain(20);
    irq = 4'b0000;
    tick();
    next_pc = 32'h340;
    exp_redir.push_back(32'h300);
    expect_entry(4'b0001, 32'h340, 32'h10);
    irq = 4'b0001;
    tick();
    rti = 1'b1;
    tick();
    rti = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || irq_ack !== 4'b0000) begin
      errors++; $display("FAIL rti_first: got redirect %b ack %b, required 1 0000", redirect_valid, irq_ack);
    end
    drain(20);
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0 || active_id !== 2'd0 || in_isr !== 1'b1) begin
      errors++; $display("FAIL rti_then_irq: got outstanding %0d id %0d isr %b, required 0 0 1", exp_redir.size() + exp_ack.size() + exp_inst.size(), active_id, in_isr);
    end
    exp_redir.push_back(32'h340);
    pulse_rti();
    drain(10);
    irq = '0;
  endtask

  task automatic test_back_to_back_stall();
    int n;
    next_pc = 32'h500;
    expect_entry(4'b0010, 32'h500, 32'h18);
    irq = 4'b0010;
    tick(); tick(); tick();
    checks++;
    if (inj_valid !== 1'b1 || inj_inst !== 16'hF801) begin
      errors++; $display("FAIL stall_inj_start: got %b %h, required 1 f801", inj_valid, inj_inst);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inj_valid !== 1'b1 || inj_inst !== 16'hF801) begin
        errors++; $display("FAIL stall_inj_hold: got %b %h, required 1 f801", inj_valid, inj_inst);
      end
    end
    stall = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (redirect_valid) break;
    end
    checks++;
    if (n + 6 !== 8) begin
      errors++; $display("FAIL stall_latency: got %0d, required 8", n + 6);
    end
    drain(10);
    irq = '0;
    exp_redir.push_back(32'h500);
    pulse_rti();
    drain(10);
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0 || in_isr !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got outstanding %0d isr %b, required 0 0", exp_redir.size() + exp_ack.size() + exp_inst.size(), in_isr);
    end
  endtask

  task automatic test_err_and_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clean: got %b, required 0", err);
    end
    pulse_rti();
    checks++;
    if (err !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL err_set: got err %b redirect %b, required 1 0", err, redirect_valid);
    end
    tick(); tick(); tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b, required 1", err);
    end
    next_pc = 32'h600;
    exp_ack.push_back(4'b1000);
    exp_inst.push_back(16'hF801); exp_spc.push_back(32'h600);
    irq = 4'b1000;
    tick(); tick(); tick(); tick();
    checks++;
    if (inj_inst !== 16'hF802 || saved_pc !== 32'h600) begin
      errors++; $display("FAIL inj_lo: got %h %h, required f802 00000600", inj_inst, saved_pc);
    end
    reset = 1'b0;
    irq = '0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_mid_seq: got %h, required 0", obs);
    end
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (exp_redir.size() + exp_ack.size() + exp_inst.size() != 0 || fetch_hold !== 1'b0 || in_isr !== 1'b0) begin
      errors++; $display("FAIL reset_after: got outstanding %0d hold %b isr %b, required 0 0 0", exp_redir.size() + exp_ack.size() + exp_inst.size(), fetch_hold, in_isr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nest();
    test_mask();
    test_rti_irq();
    test_back_to_back_stall();
    test_err_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
